// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter: FSM state encoding,
//   the default grant-hold watchdog limit and the nominal UART timing
//   constants of the system the arbiter sits in.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_ACK   = 3'd3,
    S_DRAIN = 3'd4,
    S_GAP   = 3'd5
  } arb_state_e;

  localparam int TMO_DEFAULT  = 4096;
  localparam int CLK_HZ       = 42_000_000;
  localparam int OVERSAMPLE   = 16;
  localparam int BAUD_DIV     = 44;
  localparam int FRAME_BITS   = 10;
  // Clocks per transmitted frame (start + 8 data + stop).
  localparam int FRAME_CYCLES = OVERSAMPLE * BAUD_DIV * FRAME_BITS;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// uart_tx_arbiter_rr
//   Combinational round-robin pick: the first asserted request at or after
//   the pointer, wrapping past N-1 back to 0.
//   i_req  [N]       request vector
//   i_ptr  [log2 N]  highest-priority lane this round
//   o_grant[N]       one-hot winner (0 when no request)
//   o_idx  [log2 N]  index of the winner (0 when no request)
module uart_tx_arbiter_rr #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);

  always_comb begin
    int  j;
    logic w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = PW'(j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte sources. Ownership is
//   granted round-robin per message (a burst of bytes ended by in_last) and
//   each byte is handed to the UART with a start pulse, then the arbiter
//   waits for the UART busy cycle before taking the next byte.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   req[N]          requester wants the link for a whole message
//   in_valid[N]     byte presented on in_data lane i
//   in_data[8N]     flattened byte lanes
//   in_last[N]      byte on lane i closes the message
//   in_ready[N]     one-hot, high only while waiting for the owner's byte
//   grant[N]        one-hot current owner, 0 when idle
//   uart_tx_start   one-cycle pulse to the transmitter
//   uart_tx_data    byte held from start pulse until busy falls
//   uart_tx_busy    transmitter busy
// Configuration
//   UART_ARB_TIMEOUT_EN  adds a watchdog that releases an owner stalled in
//                        LOAD, and bounds the wait for busy in ACK.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = TMO_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [8*N_REQ-1:0] in_data,
  input  logic [N_REQ-1:0]   in_last,
  output logic [N_REQ-1:0]   in_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               uart_tx_start,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  arb_state_e             r_state, w_state_nxt;
  logic [N_REQ-1:0]       r_grant;
  logic [PTR_W-1:0]       r_gidx;
  logic [PTR_W-1:0]       r_ptr;
  logic [7:0]             r_data;
  logic                   r_last;
  logic [GAP_W-1:0]       r_gap_cnt;

  logic [N_REQ-1:0][7:0]  w_lanes;
  logic [N_REQ-1:0]       w_rr_grant;
  logic [PTR_W-1:0]       w_rr_idx;
  logic                   w_sel_valid, w_sel_req;
  logic                   w_take, w_accept, w_release, w_abort, w_done;
  logic                   w_gap_ld, w_tmo_hit;

  assign w_lanes     = in_data;
  assign w_sel_valid = in_valid[r_gidx];
  assign w_sel_req   = req[r_gidx];

  uart_tx_arbiter_rr #(.N(N_REQ), .PW(PTR_W)) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Restarts on every state change, so an accepted byte (LOAD->START)
  // always clears it; only counts while parked in LOAD or ACK.
  always_ff @(posedge clk) begin
    if (rst || (r_state != w_state_nxt))
      r_tmo_cnt <= '0;
    else if (r_state == S_LOAD || r_state == S_ACK)
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  assign w_tmo_hit = (int'(r_tmo_cnt) == TIMEOUT_CYCLES - 1);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_abort     = 1'b0;
    w_done      = 1'b0;
    w_gap_ld    = 1'b0;
    case (r_state)
      S_IDLE:
        if (|req) begin
          w_take      = 1'b1;
          w_state_nxt = S_LOAD;
        end
      S_LOAD:
        if (w_sel_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_START;
        end else if (!w_sel_req) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      S_START: w_state_nxt = S_ACK;
      S_ACK:
        if (uart_tx_busy || w_tmo_hit) w_state_nxt = S_DRAIN;
      S_DRAIN:
        // The cycle busy is seen low counts as the first gap cycle.
        if (!uart_tx_busy) begin
          if (GAP_CYCLES > 1) begin
            w_gap_ld    = 1'b1;
            w_state_nxt = S_GAP;
          end else begin
            w_done = 1'b1;
          end
        end
      S_GAP:
        if (int'(r_gap_cnt) == GAP_CYCLES - 1) w_done = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    // A requester that dropped req while its byte was in flight is
    // released exactly as if that byte had been marked last.
    if (w_done) begin
      if (r_last || !w_sel_req) begin
        w_release   = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_gap_cnt <= '0;
    end else begin
      if (w_take) begin
        r_grant <= w_rr_grant;
        r_gidx  <= w_rr_idx;
      end
      if (w_accept) begin
        r_data <= w_lanes[r_gidx];
        r_last <= in_last[r_gidx];
      end
      if (w_abort) r_grant <= '0;
      // Releasing owner drops to lowest priority for the next round.
      if (w_release) begin
        r_grant <= '0;
        r_ptr   <= (int'(r_gidx) == N_REQ - 1) ? '0 : r_gidx + PTR_W'(1);
      end
      if (w_gap_ld)              r_gap_cnt <= GAP_W'(1);
      else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end
  end

  assign grant         = r_grant;
  assign in_ready      = (r_state == S_LOAD) ? r_grant : '0;
  assign uart_tx_start = (r_state == S_START);
  assign uart_tx_data  = r_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 7040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // DUT A: GAP_CYCLES=10, main scenarios
  logic        rst_a = 1'b1;
  logic [3:0]  req_a = '0, vld_a = '0, last_a = '0, rdy_a, grant_a;
  logic [31:0] dat_a = '0;
  logic        start_a, busy_a;
  logic [7:0]  tdata_a;
  int          bcnt_a = 0;

  // DUT B: GAP_CYCLES=0, gap latency only
  logic        rst_b = 1'b1;
  logic [3:0]  req_b = '0, vld_b = '0, last_b = '0, rdy_b, grant_b;
  logic [31:0] dat_b = '0;
  logic        start_b, busy_b;
  logic [7:0]  tdata_b;
  int          bcnt_b = 0;
  logic        done_b = 1'b0;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(10), .TIMEOUT_CYCLES(64)) u_dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .in_valid(vld_a), .in_data(dat_a),
    .in_last(last_a), .in_ready(rdy_a), .grant(grant_a),
    .uart_tx_start(start_a), .uart_tx_data(tdata_a), .uart_tx_busy(busy_a)
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .in_valid(vld_b), .in_data(dat_b),
    .in_last(last_b), .in_ready(rdy_b), .grant(grant_b),
    .uart_tx_start(start_b), .uart_tx_data(tdata_b), .uart_tx_busy(busy_b)
  );

  // UART busy models: high from the cycle after start for BUSY_LEN cycles.
  always @(posedge clk) begin
    if (start_a)         bcnt_a <= BUSY_LEN;
    else if (bcnt_a != 0) bcnt_a <= bcnt_a - 1;
    if (start_b)         bcnt_b <= BUSY_LEN;
    else if (bcnt_b != 0) bcnt_b <= bcnt_b - 1;
  end
  assign busy_a = (bcnt_a != 0);
  assign busy_b = (bcnt_b != 0);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int lane, input logic [7:0] d, input logic last, input string tag);
    int n;
    n = 0;
    vld_a[lane] = 1'b1;
    dat_a[8*lane +: 8] = d;
    last_a[lane] = last;
    while (!rdy_a[lane] && n < 8000) begin tick; n++; end
    chk({tag, "_rdy"}, {31'd0, rdy_a[lane]}, 1);
    tick;
    vld_a  = '0;
    last_a = '0;
    chk({tag, "_start"}, {31'd0, start_a}, 1);
    chk({tag, "_data"}, {24'd0, tdata_a}, {24'd0, d});
  endtask

  // Returns on the first cycle busy is sampled low after going high.
  task automatic busy_fall_a(input string tag);
    int n;
    n = 0;
    while (!busy_a && n < 10) begin tick; n++; end
    n = 0;
    while (busy_a && n < 8000) begin tick; n++; end
    chk({tag, "_busyfall"}, {31'd0, busy_a}, 0);
  endtask

  task automatic wait_grant_a(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    while (grant_a !== exp && n < 100) begin tick; n++; end
    chk({tag, "_grant"}, {28'd0, grant_a}, {28'd0, exp});
  endtask

  task automatic reset_a;
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
  endtask

  // DUT B: 2-byte message, busy fall to next in_ready must be 1 cycle.
  initial begin : dut_b_seq
    int n;
    tick;
    rst_b = 1'b0;
    req_b = 4'b0001;
    vld_b = 4'b0001;
    dat_b[7:0] = 8'hA1;
    n = 0;
    while (!rdy_b[0] && n < 10) begin tick; n++; end
    tick;
    vld_b = '0;
    chk("b_start0", {31'd0, start_b}, 1);
    chk("b_data0", {24'd0, tdata_b}, 32'hA1);
    n = 0;
    while (!busy_b && n < 10) begin tick; n++; end
    n = 0;
    while (busy_b && n < 8000) begin tick; n++; end
    n = 0;
    while (!rdy_b[0] && n < 50) begin tick; n++; end
    chk("b_gap0", n, 1);
    vld_b = 4'b0001; last_b = 4'b0001; dat_b[7:0] = 8'hA2;
    tick;
    vld_b = '0; last_b = '0; req_b = '0;
    chk("b_data1", {24'd0, tdata_b}, 32'hA2);
    n = 0;
    while (!busy_b && n < 10) begin tick; n++; end
    n = 0;
    while (busy_b && n < 8000) begin tick; n++; end
    tick;
    chk("b_release", {28'd0, grant_b}, 0);
    done_b = 1'b1;
  end

  initial begin : dut_a_seq
    int n;
    tick;
    tick;
`ifdef UART_ARB_TIMEOUT_EN
    // stalled owner loses the link after 64 cycles in LOAD
    reset_a;
    req_a = 4'b0010;
    tick;
    chk("t6_grant", {28'd0, grant_a}, 32'h2);
    n = 0;
    while (grant_a == 4'b0010 && n < 200) begin tick; n++; end
    req_a = '0;
    chk("t6_tmo", n, 64);
`endif
    // Test 1: reset state, single requester, 2-byte message
    rst_a = 1'b1;
    tick;
    chk("rst_grant", {28'd0, grant_a}, 0);
    chk("rst_rdy",   {28'd0, rdy_a}, 0);
    chk("rst_start", {31'd0, start_a}, 0);
    chk("rst_data",  {24'd0, tdata_a}, 0);
    rst_a = 1'b0;
    req_a = 4'b0001;
    tick;
    chk("t1_grant", {28'd0, grant_a}, 32'h1);
    chk("t1_rdy",   {28'd0, rdy_a}, 32'h1);
    send_a(0, 8'h41, 1'b0, "t1b0");
    tick;
    chk("t1_pulse", {31'd0, start_a}, 0);
    busy_fall_a("t1b0");
    chk("t1_hold", {24'd0, tdata_a}, 32'h41);
    n = 0;
    while (!rdy_a[0] && n < 50) begin tick; n++; end
    chk("t1_gap10", n, 10);
    send_a(0, 8'h42, 1'b1, "t1b1");
    req_a = '0;
    busy_fall_a("t1b1");
    chk("t1_grant_mid", {28'd0, grant_a}, 32'h1);
    n = 0;
    while (grant_a != 4'b0000 && n < 50) begin tick; n++; end
    chk("t1_release", n, 10);

    // Test 2: lanes 0 and 2 together, pointer 0; no interleave
    reset_a;
    req_a = 4'b0101;
    tick;
    chk("t2_grant0", {28'd0, grant_a}, 32'h1);
    send_a(0, 8'h10, 1'b0, "t2b0");
    busy_fall_a("t2b0");
    chk("t2_hold", {28'd0, grant_a}, 32'h1);
    send_a(0, 8'h11, 1'b1, "t2b1");
    chk("t2_noready2", {28'd0, rdy_a}, 0);
    req_a = 4'b0100;
    busy_fall_a("t2b1");
    wait_grant_a(4'b0100, "t2_l2");
    send_a(2, 8'h20, 1'b1, "t2b2");
    req_a = '0;
    busy_fall_a("t2b2");
    wait_grant_a(4'b0000, "t2_idle");

    // Test 3: lane 3 message, then 1001 -> lane 0 after pointer wrap
    req_a = 4'b1000;
    wait_grant_a(4'b1000, "t3_l3");
    send_a(3, 8'h33, 1'b1, "t3b0");
    req_a = 4'b1001;
    busy_fall_a("t3b0");
    wait_grant_a(4'b0001, "t3_wrap");
    req_a = 4'b0001;
    send_a(0, 8'h01, 1'b1, "t3b1");
    req_a = '0;
    busy_fall_a("t3b1");
    wait_grant_a(4'b0000, "t3_idle");

    // Test 5: reset during DRAIN, then a fresh request is served
    req_a = 4'b0010;
    wait_grant_a(4'b0010, "t5_l1");
    send_a(1, 8'h55, 1'b1, "t5b0");
    n = 0;
    while (!busy_a && n < 10) begin tick; n++; end
    tick;
    rst_a = 1'b1;
    tick;
    chk("t5_grant", {28'd0, grant_a}, 0);
    chk("t5_start", {31'd0, start_a}, 0);
    chk("t5_rdy",   {28'd0, rdy_a}, 0);
    chk("t5_busy",  {31'd0, busy_a}, 1);
    rst_a = 1'b0;
    req_a = '0;
    n = 0;
    while (busy_a && n < 8000) begin tick; n++; end
    req_a = 4'b0100;
    wait_grant_a(4'b0100, "t5_l2");
    send_a(2, 8'h66, 1'b1, "t5b1");
    req_a = '0;
    tick;

    chk("b_done", {31'd0, done_b}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
